video_fetch: RTL and testbench

VIDEO_FETCH -- requirements
Module: video_fetch

---
 rtl/video_fetch.sv | 177 +++++++++++++++++
 tb/tb_video_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch.sv
// ----------------------------------------------------------------------------
// video_fetch
//
// Streams one frame of pixel bytes from a byte-wide synchronous memory into a
// small FIFO and presents them to a pixel consumer with valid/ready handshake.
// A frame is LINES*LINE_BYTES consecutive bytes starting at base_addr; the
// address pointer wraps from 0xFFFF to 0x0000. Reads are only issued while the
// FIFO plus the one possible in-flight read still has room, so the FIFO can
// never overflow regardless of how the consumer stalls.
//
// Ports
//   clk          sole clock, all state on rising edge
//   reset        asynchronous active-high reset
//   frame_start  one-cycle pulse starting (or restarting) a frame fetch
//   base_addr    frame base byte address, sampled on frame_start
//   mem_en       memory read enable, one byte per asserted cycle
//   mem_addr     memory read byte address
//   mem_dout     memory read data, valid one cycle after mem_en
//   pix_valid    FIFO head byte available
//   pix_ready    consumer accepts the head byte when high with pix_valid
//   pix_data     FIFO head byte (zero while the FIFO is empty)
//   line_end     head byte is the last byte of a scanline
//   frame_done   one-cycle pulse once the frame's final byte has been accepted
// ----------------------------------------------------------------------------
module video_fetch #(
    parameter int DEPTH      = 8,
    parameter int LINE_BYTES = 40,
    parameter int LINES      = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [15:0] base_addr,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_dout,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_data,
    output logic        line_end,
    output logic        frame_done
);

    localparam int TOTAL = LINES * LINE_BYTES;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int COL_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;

    localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_BYTES - 1);
    localparam logic [OCC_W:0]   DEPTH_C  = (OCC_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [15:0]      ptr_q,      ptr_d;
    logic [CNT_W-1:0] issued_q,   issued_d;
    logic             inflight_q, inflight_d;
    logic [IDX_W-1:0] wr_idx_q,   wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q,   rd_idx_d;
    logic [OCC_W-1:0] count_q,    count_d;
    logic [COL_W-1:0] col_q,      col_d;
    logic [7:0]       fifo_q [DEPTH];

    logic space_ok;
    logic issue;
    logic push;
    logic pop;
    logic drain_done;

    // Handshake and output decode. A frame_start cycle suppresses issue, push
    // and pop so that the restart begins from a completely clean FIFO and no
    // read from the aborted frame can land after the flush.
    always_comb begin
        space_ok   = ({1'b0, count_q} + {{OCC_W{1'b0}}, inflight_q}) < DEPTH_C;
        issue      = (state_q == ST_FETCH) && space_ok && !frame_start;
        push       = inflight_q && !frame_start;
        pix_valid  = (count_q != '0);
        pop        = pix_valid && pix_ready && !frame_start;
        drain_done = (state_q == ST_DRAIN) && (count_q == '0) && !inflight_q;
        frame_done = drain_done && !frame_start;
        pix_data   = pix_valid ? fifo_q[rd_idx_q] : 8'h00;
        line_end   = pix_valid && (col_q == LAST_COL);
        mem_en     = issue;
        mem_addr   = ptr_q;
    end

    // Next-state logic for the sequencer, the read pointer, the FIFO pointers
    // and the popped-byte column counter. frame_start is applied last so it
    // overrides both normal progress and the DRAIN -> IDLE completion.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        issued_d   = issued_q;
        inflight_d = issue;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        count_d    = count_q;
        col_d      = col_q;

        if (issue) begin
            ptr_d    = ptr_q + 16'd1;
            issued_d = issued_q + CNT_W'(1);
            if (issued_q + CNT_W'(1) == TOTAL_C) begin
                state_d = ST_DRAIN;
            end
        end

        if (push) begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
        end

        if (pop) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            col_d    = (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        if (drain_done) begin
            state_d = ST_IDLE;
        end

        if (frame_start) begin
            state_d    = ST_FETCH;
            ptr_d      = base_addr;
            issued_d   = '0;
            inflight_d = 1'b0;
            wr_idx_d   = '0;
            rd_idx_d   = '0;
            count_d    = '0;
            col_d      = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            count_q    <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            count_q    <= count_d;
            col_q      <= col_d;
        end
    end

    // FIFO storage; the byte returned for last cycle's read is captured here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else if (push) begin
            fifo_q[wr_idx_q] <= mem_dout;
        end
    end

endmodule

// File: tb/tb_video_fetch.sv
// ----------------------------------------------------------------------------
// tb_video_fetch
//
// Directed bench for video_fetch. The main instance uses the default frame
// geometry (40 x 200 bytes, 8-byte FIFO); a second instance with a 4-byte,
// single-line frame exercises address wrap and frame completion timing.
// The memory model returns addr[7:0] ^ addr[15:8] one cycle after mem_en.
// ----------------------------------------------------------------------------
module tb_video_fetch;

    logic        clk = 1'b0;
    logic        reset;

    logic        frame_start;
    logic [15:0] base_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout = 8'h00;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        line_end;
    logic        frame_done;

    logic        frame_start_s;
    logic [15:0] base_addr_s;
    logic        mem_en_s;
    logic [15:0] mem_addr_s;
    logic [7:0]  mem_dout_s = 8'h00;
    logic        pix_valid_s;
    logic        pix_ready_s;
    logic [7:0]  pix_data_s;
    logic        line_end_s;
    logic        frame_done_s;

    int checks_total  = 0;
    int checks_failed = 0;

    always #5 clk = ~clk;

    video_fetch #(.DEPTH(8), .LINE_BYTES(40), .LINES(200)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .base_addr(base_addr),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .line_end(line_end), .frame_done(frame_done)
    );

    video_fetch #(.DEPTH(8), .LINE_BYTES(4), .LINES(1)) dut_small (
        .clk(clk), .reset(reset), .frame_start(frame_start_s), .base_addr(base_addr_s),
        .mem_en(mem_en_s), .mem_addr(mem_addr_s), .mem_dout(mem_dout_s),
        .pix_valid(pix_valid_s), .pix_ready(pix_ready_s), .pix_data(pix_data_s),
        .line_end(line_end_s), .frame_done(frame_done_s)
    );

    function automatic logic [7:0] mem_model(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Synchronous read memory shared by both instances.
    always @(posedge clk) begin
        if (mem_en)   mem_dout   <= mem_model(mem_addr);
        if (mem_en_s) mem_dout_s <= mem_model(mem_addr_s);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Scoreboard for the main instance: expected issue address, expected pop
    // address and column, and outstanding-byte bound.
    logic        mon_en = 1'b0;
    logic [15:0] exp_issue_addr = 16'h0000;
    logic [15:0] exp_pop_addr   = 16'h0000;
    int          issued_cnt     = 0;
    int          popped_cnt     = 0;
    int          exp_col        = 0;
    int          frame_done_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_start) begin
                exp_issue_addr = base_addr;
                exp_pop_addr   = base_addr;
                issued_cnt     = 0;
                popped_cnt     = 0;
                exp_col        = 0;
            end else begin
                if (mem_en) begin
                    checkOutput("mem_addr", mem_addr, exp_issue_addr);
                    exp_issue_addr = exp_issue_addr + 16'd1;
                    issued_cnt++;
                end
                checkOutput("occupancy_le_depth", 32'((issued_cnt - popped_cnt) <= 8), 1);
                if (pix_valid && pix_ready) begin
                    checkOutput("pix_data", pix_data, mem_model(exp_pop_addr));
                    checkOutput("line_end", line_end, 32'(exp_col == 39));
                    exp_pop_addr = exp_pop_addr + 16'd1;
                    popped_cnt++;
                    exp_col = (exp_col == 39) ? 0 : exp_col + 1;
                end
                if (frame_done) frame_done_cnt++;
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] base);
        @(posedge clk); #1;
        base_addr   = base;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        checkOutput("first_mem_en", mem_en, 1);
        checkOutput("first_mem_addr", mem_addr, base);
    endtask

    int          fd0;
    int          wait_cycles;
    int          n_iss, n_pop, n_done, done_cycle, last_pop_cycle;
    logic [15:0] iss_addr [4];
    logic [7:0]  pop_data [4];
    logic        pop_le   [4];
    logic [15:0] exp_small [4];

    initial begin
        reset         = 1'b0;
        frame_start   = 1'b0;
        base_addr     = 16'h0000;
        pix_ready     = 1'b0;
        frame_start_s = 1'b0;
        base_addr_s   = 16'h0000;
        pix_ready_s   = 1'b0;
        exp_small     = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        // Reset values, checked before any clock edge.
        #1 reset = 1'b1;
        #2;
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_pix_valid", pix_valid, 0);
        checkOutput("rst_pix_data", pix_data, 0);
        checkOutput("rst_line_end", line_end, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_small_mem_en", mem_en_s, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Full frame at 0x4000 with the consumer always ready.
        $display("[TB] full frame, pix_ready held high");
        pix_ready = 1'b1;
        mon_en    = 1'b1;
        fd0       = frame_done_cnt;
        applyStimulus(16'h4000);
        for (wait_cycles = 0; wait_cycles < 9000 && frame_done_cnt == fd0; wait_cycles++)
            @(posedge clk);
        checkOutput("A_frame_done_seen", frame_done_cnt, fd0 + 1);
        checkOutput("A_issued", issued_cnt, 8000);
        checkOutput("A_popped", popped_cnt, 8000);
        checkOutput("A_throughput", 32'(wait_cycles < 8010), 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("A_single_frame_done", frame_done_cnt, fd0 + 1);
        checkOutput("A_idle_no_mem_en", mem_en, 0);

        // Consumer stalled: FIFO fills to exactly DEPTH and reads stop.
        $display("[TB] consumer stalled");
        @(posedge clk); #1 pix_ready = 1'b0;
        applyStimulus(16'h1000);
        repeat (30) @(posedge clk);
        @(negedge clk);
        checkOutput("B_issued_8", issued_cnt, 8);
        checkOutput("B_pix_valid", pix_valid, 1);
        checkOutput("B_mem_en_low", mem_en, 0);
        checkOutput("B_head_data", pix_data, mem_model(16'h1000));
        @(posedge clk); #1 pix_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("B_resume", 32'(issued_cnt > 8), 1);

        // Restart mid-frame, then finish the new frame under random backpressure.
        $display("[TB] frame restart and random pix_ready");
        fd0 = frame_done_cnt;
        applyStimulus(16'h4000);
        for (int i = 0; i < 1000 && popped_cnt < 100; i++) @(posedge clk);
        checkOutput("C_reached_100", 32'(popped_cnt >= 100), 1);
        applyStimulus(16'h2000);
        for (int i = 0; i < 10 && !pix_valid; i++) @(negedge clk);
        checkOutput("C_restart_data", pix_data, mem_model(16'h2000));
        checkOutput("C_restart_line_end", line_end, 0);
        for (int i = 0; i < 40000 && frame_done_cnt == fd0; i++) begin
            @(posedge clk); #1;
            pix_ready = 1'($urandom_range(0, 1));
        end
        checkOutput("C_frame_done_once", frame_done_cnt, fd0 + 1);
        checkOutput("C_popped", popped_cnt, 8000);
        checkOutput("C_issued", issued_cnt, 8000);

        // Reset mid-fetch with a read in flight.
        $display("[TB] reset during fetch");
        @(posedge clk); #1 pix_ready = 1'b1;
        applyStimulus(16'h3000);
        repeat (5) @(posedge clk);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        checkOutput("D_rst_mem_en", mem_en, 0);
        checkOutput("D_rst_mem_addr", mem_addr, 0);
        checkOutput("D_rst_pix_valid", pix_valid, 0);
        checkOutput("D_rst_pix_data", pix_data, 0);
        checkOutput("D_rst_line_end", line_end, 0);
        checkOutput("D_rst_frame_done", frame_done, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("D_no_mem_en", mem_en, 0);
            checkOutput("D_no_push", pix_valid, 0);
        end

        // Small instance: 4-byte frame crossing the 0xFFFF boundary.
        $display("[TB] small frame with address wrap");
        pix_ready_s = 1'b1;
        @(posedge clk); #1;
        base_addr_s   = 16'hFFFE;
        frame_start_s = 1'b1;
        @(posedge clk); #1;
        frame_start_s = 1'b0;
        n_iss = 0; n_pop = 0; n_done = 0; done_cycle = -1; last_pop_cycle = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_en_s) begin
                if (n_iss < 4) iss_addr[n_iss] = mem_addr_s;
                n_iss++;
            end
            if (pix_valid_s && pix_ready_s) begin
                if (n_pop < 4) begin
                    pop_data[n_pop] = pix_data_s;
                    pop_le[n_pop]   = line_end_s;
                end
                n_pop++;
                last_pop_cycle = c;
            end
            if (frame_done_s) begin
                n_done++;
                done_cycle = c;
            end
        end
        checkOutput("E_issue_count", n_iss, 4);
        checkOutput("E_pop_count", n_pop, 4);
        if (n_iss == 4 && n_pop == 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("E_mem_addr", iss_addr[k], exp_small[k]);
                checkOutput("E_pix_data", pop_data[k], mem_model(exp_small[k]));
                checkOutput("E_line_end", pop_le[k], 32'(k == 3));
            end
        end
        checkOutput("E_frame_done_count", n_done, 1);
        checkOutput("E_frame_done_timing", done_cycle, last_pop_cycle + 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks_total, checks_failed);
        $finish;
    end

endmodule
